// File: rtl/visor_banco_scan.sv
// rtl/visor_banco_scan.sv - multiplexed 7-segment scanner reading nibbles from the register bank (optional LEADING_ZERO_BLANK_EN)
module visor_banco_scan #(
    parameter int BIT_ADDR = 8,
    parameter int BIT_DATO = 4,
    parameter int N_DIG    = 4,
    parameter int DIV      = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [BIT_ADDR-1:0] base_addr,
    input  logic [BIT_DATO-1:0] datIn,
    output logic [BIT_ADDR-1:0] addrR,
    output logic [N_DIG-1:0]    an,
    output logic [6:0]          sseg,
    output logic                frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [DW-1:0] DIG_TOP  = DW'(N_DIG - 1);

    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_dig;
    logic [BIT_ADDR-1:0] r_addr;
    logic [N_DIG-1:0]    r_an;
    logic [6:0]          r_sseg;
    logic                r_frame_done;
    // Set on the edge that moved to a new digit; the bank data for that
    // address is captured one edge later, which gives the guard blank cycle.
    logic                r_pend;

    logic                w_tick;
    logic [DW-1:0]       w_dig_next;
    logic [BIT_ADDR-1:0] w_addr_next;
    logic [N_DIG-1:0]    w_an_lit;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg_dec;
    logic [6:0]          w_seg_out;

    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_dig_next  = (r_dig == '0) ? DIG_TOP : (r_dig - DW'(1));
    assign w_addr_next = base_addr + BIT_ADDR'(w_dig_next);
    assign w_an_lit    = ~(N_DIG'(1) << r_dig);

    // Narrow banks are zero-extended to a full nibble before decoding.
    generate
        if (BIT_DATO >= 4) begin : g_nib_wide
            assign w_nib = datIn[3:0];
        end else begin : g_nib_narrow
            assign w_nib = {{(4 - BIT_DATO){1'b0}}, datIn};
        end
    endgenerate

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nib)
            4'h0: w_seg_dec = 7'b1000000;
            4'h1: w_seg_dec = 7'b1111001;
            4'h2: w_seg_dec = 7'b0100100;
            4'h3: w_seg_dec = 7'b0110000;
            4'h4: w_seg_dec = 7'b0011001;
            4'h5: w_seg_dec = 7'b0010010;
            4'h6: w_seg_dec = 7'b0000010;
            4'h7: w_seg_dec = 7'b1111000;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0010000;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b0000011;
            4'hC: w_seg_dec = 7'b1000110;
            4'hD: w_seg_dec = 7'b0100001;
            4'hE: w_seg_dec = 7'b0000110;
            4'hF: w_seg_dec = 7'b0001110;
            default: w_seg_dec = 7'h7F;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic r_nz;
    logic w_nz_eff;
    logic w_blank;

    // The MSB digit starts a fresh frame, so it sees the flag as cleared.
    assign w_nz_eff  = (r_dig == DIG_TOP) ? 1'b0 : r_nz;
    assign w_blank   = (r_dig != '0) && (w_nib == 4'd0) && !w_nz_eff;
    assign w_seg_out = w_blank ? 7'h7F : w_seg_dec;

    // Remember whether a non-zero digit has been shown so far in this frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nz <= 1'b0;
        end else if (en && r_pend) begin
            r_nz <= w_nz_eff | (w_nib != 4'd0);
        end
    end
`else
    assign w_seg_out = w_seg_dec;
`endif

    // Prescaler: one tick per DIV cycles while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Digit selector and bank read address advance on each tick, MSB first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dig  <= DIG_TOP;
            r_addr <= '0;
            r_pend <= 1'b0;
        end else if (!en) begin
            r_dig  <= DIG_TOP;
            r_pend <= 1'b0;
        end else if (w_tick) begin
            r_dig  <= w_dig_next;
            r_addr <= w_addr_next;
            r_pend <= 1'b1;
        end else begin
            r_pend <= 1'b0;
        end
    end

    // Display drive: blank on the tick edge, light the new digit one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an         <= '1;
            r_sseg       <= 7'h7F;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_tick) begin
                r_an <= '1;
            end else if (r_pend) begin
                r_an         <= w_an_lit;
                r_sseg       <= w_seg_out;
                r_frame_done <= (r_dig == '0);
            end
        end
    end

    assign addrR      = r_addr;
    assign an         = r_an;
    assign sseg       = r_sseg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_visor_banco_scan.sv
// tb/tb_visor_banco_scan.sv - directed self-checking bench for visor_banco_scan
module tb_visor_banco_scan;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] base_addr;
    logic [3:0] datIn;
    logic [7:0] addrR;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       frame_done;

    logic [3:0] bank [0:255];
    int tests;
    int fails;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZERO_LEAD = 7'h7F;
`else
    localparam logic [6:0] ZERO_LEAD = 7'b1000000;
`endif

    visor_banco_scan #(
        .BIT_ADDR(8),
        .BIT_DATO(4),
        .N_DIG   (4),
        .DIV     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .base_addr (base_addr),
        .datIn     (datIn),
        .addrR     (addrR),
        .an        (an),
        .sseg      (sseg),
        .frame_done(frame_done)
    );

    assign datIn = bank[addrR];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic slot(input string tag, input bit first, input logic [7:0] e_addr,
                        input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_fd);
        cyc(first ? 4 : 3);
        chk({tag, "_guard_an"}, 32'(an), 32'hF);
        chk({tag, "_addr"}, 32'(addrR), 32'(e_addr));
        cyc(1);
        chk({tag, "_an"}, 32'(an), 32'(e_an));
        chk({tag, "_sseg"}, 32'(sseg), 32'(e_seg));
        chk({tag, "_fd"}, 32'(frame_done), 32'(e_fd));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk = 1'b0;
        rst = 1'b0;
        en = 1'b0;
        base_addr = 8'h10;
        for (int i = 0; i < 256; i++) bank[i] = 4'h0;
        bank[8'h10] = 4'h1; bank[8'h11] = 4'h2; bank[8'h12] = 4'h3; bank[8'h13] = 4'h4;
        bank[8'h22] = 4'h7; bank[8'h21] = 4'h9;
        bank[8'h00] = 4'hA; bank[8'hFF] = 4'hB; bank[8'hFE] = 4'hC; bank[8'h01] = 4'hD;
        bank[8'h43] = 4'h0; bank[8'h42] = 4'h0; bank[8'h41] = 4'h5; bank[8'h40] = 4'h0;

        cyc(2);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'h7F);
        chk("rst_addr", 32'(addrR), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);

        // Normal scan, base 0x10, bank 1,2,3,4
        rst = 1'b1;
        en = 1'b1;
        slot("scan_d2", 1'b1, 8'h12, 4'b1011, 7'b0110000, 1'b0);
        slot("scan_d1", 1'b0, 8'h11, 4'b1101, 7'b0100100, 1'b0);
        slot("scan_d0", 1'b0, 8'h10, 4'b1110, 7'b1111001, 1'b1);
        cyc(1);
        chk("fd_single", 32'(frame_done), 32'h0);
        cyc(2);
        chk("scan_d3_guard_an", 32'(an), 32'hF);
        chk("scan_d3_addr", 32'(addrR), 32'h13);
        cyc(1);
        chk("scan_d3_an", 32'(an), 32'b0111);
        chk("scan_d3_sseg", 32'(sseg), 32'b0011001);
        slot("scan2_d2", 1'b0, 8'h12, 4'b1011, 7'b0110000, 1'b0);

        // Enable drop mid-slot, base change while disabled
        en = 1'b0;
        base_addr = 8'h20;
        cyc(1);
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_addr", 32'(addrR), 32'h12);
        chk("dis_sseg", 32'(sseg), 32'b0110000);
        cyc(2);
        chk("dis_hold_an", 32'(an), 32'hF);
        chk("dis_hold_addr", 32'(addrR), 32'h12);
        en = 1'b1;
        slot("reen_d2", 1'b1, 8'h22, 4'b1011, 7'b1111000, 1'b0);

        // Enable drop between tick and latch: no digit lights
        cyc(3);
        chk("abort_guard_an", 32'(an), 32'hF);
        chk("abort_addr", 32'(addrR), 32'h21);
        en = 1'b0;
        cyc(1);
        chk("abort_an", 32'(an), 32'hF);
        chk("abort_sseg", 32'(sseg), 32'b1111000);
        chk("abort_fd", 32'(frame_done), 32'h0);

        // Address wrap, base 0xFE
        base_addr = 8'hFE;
        en = 1'b1;
        slot("wrap_d2", 1'b1, 8'h00, 4'b1011, 7'b0001000, 1'b0);
        slot("wrap_d1", 1'b0, 8'hFF, 4'b1101, 7'b0000011, 1'b0);
        slot("wrap_d0", 1'b0, 8'hFE, 4'b1110, 7'b1000110, 1'b1);
        slot("wrap_d3", 1'b0, 8'h01, 4'b0111, 7'b0100001, 1'b0);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_sseg", 32'(sseg), 32'h7F);
        chk("arst_addr", 32'(addrR), 32'h0);
        chk("arst_fd", 32'(frame_done), 32'h0);
        en = 1'b0;
        base_addr = 8'h40;
        cyc(1);

        // Leading-zero handling, bank digits 3..0 = 0,0,5,0
        rst = 1'b1;
        en = 1'b1;
        slot("lz_d2", 1'b1, 8'h42, 4'b1011, ZERO_LEAD, 1'b0);
        slot("lz_d1", 1'b0, 8'h41, 4'b1101, 7'b0010010, 1'b0);
        slot("lz_d0", 1'b0, 8'h40, 4'b1110, 7'b1000000, 1'b1);
        slot("lz_d3", 1'b0, 8'h43, 4'b0111, ZERO_LEAD, 1'b0);
        slot("lz2_d2", 1'b0, 8'h42, 4'b1011, ZERO_LEAD, 1'b0);
        slot("lz2_d1", 1'b0, 8'h41, 4'b1101, 7'b0010010, 1'b0);
        slot("lz2_d0", 1'b0, 8'h40, 4'b1110, 7'b1000000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
